// File: rtl/drive_cmd_pkg.sv
// drive_cmd_pkg: command type, STOP encoding and scheduler state encoding
// shared by the drive command scheduler and its FIFO.
package drive_cmd_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_STOP = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } sched_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with flush. A pop in the same cycle as a
// push on a full FIFO frees the slot first, so the push still succeeds.
// Flush dominates both push and pop.
module cmd_fifo
    import drive_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  cmd_t                   din,
    output cmd_t                   dout,
    output cmd_t                   newest,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne = 1;
    localparam logic [AW:0] LevelOne = 1;
    localparam logic [AW:0] LevelFull = DEPTH[AW:0];

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LevelFull);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign newest  = mem_q[wr_ptr_q - PtrOne];
    assign level   = level_q;

    // Storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally; occupancy tracked separately.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (do_push && !do_pop) begin
                level_q <= level_q + LevelOne;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LevelOne;
            end
        end
    end

endmodule

// File: rtl/drive_cmd_scheduler.sv
// drive_cmd_scheduler: queues drive commands for the UART path, gives STOP
// absolute priority, spaces transfers by MIN_GAP_CYCLES and re-sends the last
// command as a heartbeat after HEARTBEAT_CYCLES without a transfer.
// Optional feature: define DRIVE_CMD_SCHED_DEDUP_EN to drop a non-STOP command
// equal to the newest pending one.
module drive_cmd_scheduler
    import drive_cmd_pkg::*;
#(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned MIN_GAP_CYCLES   = 2_500_000,
    parameter int unsigned HEARTBEAT_CYCLES = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             cmd_in,
    input  logic                   cmd_valid,
    output logic [2:0]             cmd_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   heartbeat
);

    localparam int unsigned GW = $clog2(MIN_GAP_CYCLES + 1);
    localparam int unsigned HW = $clog2(HEARTBEAT_CYCLES);
    localparam logic [GW-1:0] GapLoad = GW'(MIN_GAP_CYCLES - 1);
    localparam logic [GW-1:0] GapOne  = 1;
    localparam logic [HW-1:0] HbMax   = HW'(HEARTBEAT_CYCLES - 1);
    localparam logic [HW-1:0] HbOne   = 1;
`ifdef DRIVE_CMD_SCHED_DEDUP_EN
    localparam bit DedupEn = 1'b1;
`else
    localparam bit DedupEn = 1'b0;
`endif

    sched_state_t  state_q, state_d;
    cmd_t          cur_cmd_q, cur_cmd_d;
    cmd_t          last_cmd_q;
    logic          last_valid_q;
    logic          stop_pending_q;
    logic [GW-1:0] gap_cnt_q;
    logic [HW-1:0] hb_cnt_q;
    logic          overflow_q;

    logic stop_in, norm_in, xfer;
    logic dup_hit, dup_drop, fifo_push, fifo_pop, hb_launch, clr_pending;
    logic fifo_full, fifo_empty;
    cmd_t fifo_dout, fifo_newest;

    assign stop_in   = cmd_valid && (cmd_in == CMD_STOP);
    assign norm_in   = cmd_valid && !stop_in;
    assign xfer      = (state_q == PRESENT) && out_ready;
    assign dup_drop  = DedupEn && norm_in && dup_hit;
    assign fifo_push = norm_in && !dup_drop;

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (stop_in),
        .din     (cmd_in),
        .dout    (fifo_dout),
        .newest  (fifo_newest),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Duplicate reference: newest queued entry, else the command on the output, else last sent.
    always_comb begin
        dup_hit = 1'b0;
        if (!fifo_empty) begin
            dup_hit = (cmd_in == fifo_newest);
        end else if (state_q == PRESENT) begin
            dup_hit = (cmd_in == cur_cmd_q);
        end else begin
            dup_hit = last_valid_q && (cmd_in == last_cmd_q);
        end
    end

    // Next-state: STOP > FIFO > heartbeat; a STOP arriving while IDLE blocks any launch.
    always_comb begin
        state_d     = state_q;
        cur_cmd_d   = cur_cmd_q;
        fifo_pop    = 1'b0;
        hb_launch   = 1'b0;
        clr_pending = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (stop_pending_q) begin
                    cur_cmd_d   = CMD_STOP;
                    clr_pending = 1'b1;
                    state_d     = PRESENT;
                end else if (!stop_in) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        cur_cmd_d = fifo_dout;
                        state_d   = PRESENT;
                    end else if (last_valid_q && (hb_cnt_q >= HbMax)) begin
                        hb_launch = 1'b1;
                        cur_cmd_d = last_cmd_q;
                        state_d   = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) state_d = GAP;
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, last command, STOP latch and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cur_cmd_q      <= CMD_STOP;
            last_cmd_q     <= CMD_STOP;
            last_valid_q   <= 1'b0;
            stop_pending_q <= 1'b0;
            gap_cnt_q      <= '0;
            hb_cnt_q       <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_cmd_q <= cur_cmd_d;
            if (stop_in) begin
                stop_pending_q <= 1'b1;
            end else if (clr_pending) begin
                stop_pending_q <= 1'b0;
            end
            if (xfer) begin
                last_cmd_q   <= cur_cmd_q;
                last_valid_q <= 1'b1;
                gap_cnt_q    <= GapLoad;
                hb_cnt_q     <= '0;
            end else begin
                if ((state_q == GAP) && (gap_cnt_q != '0)) gap_cnt_q <= gap_cnt_q - GapOne;
                if (hb_cnt_q != HbMax) hb_cnt_q <= hb_cnt_q + HbOne;
            end
            if (norm_in && !dup_drop && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    assign cmd_out   = cur_cmd_q;
    assign out_valid = (state_q == PRESENT);
    assign overflow  = overflow_q;
    assign heartbeat = hb_launch;

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// tb_drive_cmd_scheduler: directed table, hand sequences and randomized traffic
// checked against a time-based reference model of the scheduler.
// Honours DRIVE_CMD_SCHED_DEDUP_EN when the design is built with it.
module tb_drive_cmd_scheduler;
    import drive_cmd_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 4;
    localparam int HB      = 20;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [2:0]             cmd_in;
    logic                   cmd_valid;
    logic [2:0]             cmd_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   heartbeat;

    drive_cmd_scheduler #(
        .DEPTH            (DEPTH),
        .MIN_GAP_CYCLES   (MIN_GAP),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_in     (cmd_in),
        .cmd_valid  (cmd_valid),
        .cmd_out    (cmd_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .heartbeat  (heartbeat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Outputs sampled during the most recent tick.
    logic       s_valid, s_hb, s_ovf;
    logic [2:0] s_cmd;
    logic [2:0] s_level;

    // Reference model: queue contents, pending STOP, presented command, and the
    // time of the last transfer (gap and heartbeat both derive from it).
    logic [2:0] mq[$];
    bit         m_known = 1'b0;
    bit         m_pend, m_pres, m_have_last, m_ovf;
    logic [2:0] m_pres_cmd, m_last;
    int         m_tlast;

    typedef struct {
        int v; int c; int rdy; int ev; int ec; int el; int eo;
    } vec_t;
    vec_t tbl[15];

    function automatic bit m_idle();
        return !m_pres && (cyc > m_tlast + MIN_GAP);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_update(input int v, input int c, input int rdy, input int rn);
        bit stop_in, idle, dup;
        logic [2:0] cc;
        cc = 3'(c);
        if (rn == 0) begin
            mq.delete();
            m_pend = 0; m_pres = 0; m_have_last = 0; m_ovf = 0;
            m_tlast = -1000; m_known = 1;
            return;
        end
        stop_in = (v != 0) && (cc == CMD_STOP);
        idle = m_idle();
        dup = 1'b0;
`ifdef DRIVE_CMD_SCHED_DEDUP_EN
        if ((v != 0) && !stop_in) begin
            if (mq.size() != 0) dup = (mq[$] == cc);
            else if (m_pres) dup = (m_pres_cmd == cc);
            else dup = m_have_last && (m_last == cc);
        end
`endif
        if (m_pres && (rdy != 0)) begin
            m_last = m_pres_cmd; m_have_last = 1; m_tlast = cyc; m_pres = 0;
        end else if (idle) begin
            if (m_pend) begin
                m_pres = 1; m_pres_cmd = CMD_STOP; m_pend = 0;
            end else if (!stop_in) begin
                if (mq.size() != 0) begin
                    m_pres = 1; m_pres_cmd = mq.pop_front();
                end else if (m_have_last && (cyc >= m_tlast + HB)) begin
                    m_pres = 1; m_pres_cmd = m_last;
                end
            end
        end
        if (stop_in) begin
            mq.delete(); m_pend = 1;
        end else if ((v != 0) && !dup) begin
            if (mq.size() < DEPTH) mq.push_back(cc);
            else m_ovf = 1;
        end
    endtask

    // Drive one cycle, sample its outputs, compare with the model, advance.
    task automatic tick(input int v, input int c, input int rdy, input int rn);
        bit stop_in, exp_hb;
        cmd_valid = (v != 0);
        cmd_in    = 3'(c);
        out_ready = (rdy != 0);
        reset_n   = (rn != 0);
        #1;
        s_valid = out_valid; s_cmd = cmd_out; s_level = fifo_level;
        s_ovf = overflow; s_hb = heartbeat;
        if ((rn != 0) && m_known) begin
            stop_in = (v != 0) && (3'(c) == CMD_STOP);
            exp_hb = m_idle() && !m_pend && !stop_in && (mq.size() == 0) && m_have_last &&
                     (cyc >= m_tlast + HB);
            n_vec++;
            if (s_valid !== m_pres || (m_pres && s_cmd !== m_pres_cmd) ||
                32'(s_level) !== mq.size() || s_ovf !== m_ovf || s_hb !== exp_hb) begin
                n_bad++;
                $display("FAIL model cyc %0d: valid/cmd/level/ovf/hb got %b/%0d/%0d/%b/%b want %b/%0d/%0d/%b/%b",
                         cyc, s_valid, s_cmd, s_level, s_ovf, s_hb,
                         m_pres, m_pres_cmd, mq.size(), m_ovf, exp_hb);
            end
        end
        model_update(v, c, rdy, rn);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle with ready until out_valid; n = ticks taken, hb_at = tick of heartbeat pulse.
    task automatic next_xfer(output logic [2:0] c, output int n, output int hb_at);
        n = -1; hb_at = -1; c = 3'd7;
        for (int k = 1; k <= 60; k++) begin
            tick(0, 0, 1, 1);
            if (s_hb === 1'b1 && hb_at < 0) hb_at = k;
            if (s_valid === 1'b1) begin
                c = s_cmd; n = k;
                break;
            end
        end
        if (n < 0) begin
            n_vec++; n_bad++;
            $display("FAIL xfer_timeout: got no out_valid in 60 cycles, want one");
        end
    endtask

    // Hold ready low until out_valid, bounded.
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(0, 0, 0, 1);
            if (s_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 1);
    endtask

    initial begin
        logic [2:0] c;
        int n, hb_at, cnt, hcnt;

        tbl[0]  = '{1, 6, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 3, 0, 1, 6, 0, 0};
        tbl[3]  = '{1, 4, 0, 1, 6, 1, 0};
        tbl[4]  = '{1, 5, 0, 1, 6, 2, 0};
        tbl[5]  = '{1, 1, 0, 1, 6, 3, 0};
        tbl[6]  = '{1, 2, 0, 1, 6, 4, 0};
        tbl[7]  = '{0, 0, 0, 1, 6, 4, 1};
        tbl[8]  = '{0, 0, 1, 1, 6, 4, 1};
        tbl[9]  = '{0, 0, 1, 0, 0, 4, 1};
        tbl[10] = '{0, 0, 1, 0, 0, 4, 1};
        tbl[11] = '{0, 0, 1, 0, 0, 4, 1};
        tbl[12] = '{0, 0, 1, 0, 0, 4, 1};
        tbl[13] = '{0, 0, 1, 0, 0, 4, 1};
        tbl[14] = '{0, 0, 1, 1, 3, 3, 1};

        // Reset state
        repeat (3) tick(0, 0, 1, 0);
        tick(0, 0, 1, 1);
        check("reset_valid", 32'(s_valid), 0);
        check("reset_level", 32'(s_level), 0);
        check("reset_ovf", 32'(s_ovf), 0);
        check("reset_hb", 32'(s_hb), 0);

        // Earliest latency and spacing
        tick(1, 2, 1, 1);
        next_xfer(c, n, hb_at);
        check("s1_latency", n, 2);
        check("s1_cmd", 32'(c), 2);
        tick(1, 3, 1, 1);
        next_xfer(c, n, hb_at);
        check("s1_spacing", n, 5);
        check("s1_cmd2", 32'(c), 3);

        // Heartbeat re-send, twice
        for (int r = 0; r < 2; r++) begin
            next_xfer(c, n, hb_at);
            check("hb_resend_delay", n, HB + 1);
            check("hb_pulse_at", hb_at, HB);
            check("hb_cmd", 32'(c), 3);
        end

        // Overflow with a stalled output, table driven
        tick(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].v, tbl[i].c, tbl[i].rdy, 1);
            n_vec++;
            if (32'(s_valid) !== tbl[i].ev || (tbl[i].ev != 0 && 32'(s_cmd) !== tbl[i].ec) ||
                32'(s_level) !== tbl[i].el || 32'(s_ovf) !== tbl[i].eo) begin
                n_bad++;
                $display("FAIL table row %0d: valid/cmd/level/ovf got %b/%0d/%0d/%b want %0d/%0d/%0d/%0d",
                         i, s_valid, s_cmd, s_level, s_ovf,
                         tbl[i].ev, tbl[i].ec, tbl[i].el, tbl[i].eo);
            end
        end
        for (int i = 0; i < 3; i++) begin
            next_xfer(c, n, hb_at);
            check("ovf_order_cmd", 32'(c), (i == 0) ? 4 : (i == 1) ? 5 : 1);
            check("ovf_order_spacing", n, MIN_GAP + 2);
        end

        // STOP while another command is presented
        tick(1, 3, 0, 1);
        tick(1, 4, 0, 1);
        wait_valid("s3_present");
        check("s3_present_cmd", 32'(s_cmd), 3);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("s3_flush_level", 32'(s_level), 0);
        next_xfer(c, n, hb_at);
        check("s3_first_cmd", 32'(c), 3);
        check("s3_first_n", n, 1);
        next_xfer(c, n, hb_at);
        check("s3_stop_cmd", 32'(c), 0);
        check("s3_stop_n", n, MIN_GAP + 2);
        cnt = 0;
        for (int k = 0; k < HB - 1; k++) begin
            tick(0, 0, 1, 1);
            if (s_valid === 1'b1) cnt++;
        end
        check("s3_nothing_else", cnt, 0);
        check("s3_level_end", 32'(s_level), 0);

        // Reset while presenting with entries queued
        tick(1, 3, 0, 1);
        tick(1, 5, 0, 1);
        wait_valid("s5_present");
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        check("s5_valid", 32'(s_valid), 0);
        check("s5_level", 32'(s_level), 0);
        check("s5_ovf", 32'(s_ovf), 0);
        cnt = 0; hcnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick(0, 0, 1, 1);
            if (s_valid === 1'b1) cnt++;
            if (s_hb === 1'b1) hcnt++;
        end
        check("s5_no_send", cnt, 0);
        check("s5_no_hb", hcnt, 0);

        // Repeated identical commands
        cnt = 0;
        for (int k = 0; k < 21; k++) begin
            if (k < 3) tick(1, 4, 1, 1);
            else tick(0, 0, 1, 1);
            if (s_valid === 1'b1 && s_cmd === 3'd4) cnt++;
        end
`ifdef DRIVE_CMD_SCHED_DEDUP_EN
        check("s6_sent_4s", cnt, 1);
`else
        check("s6_sent_4s", cnt, 3);
`endif
        check("s6_ovf", 32'(s_ovf), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            int rdy_pct;
            rdy_pct = ((k / 64) % 2 == 1) ? 20 : 85;
            tick(($urandom_range(0, 99) < 40) ? 1 : 0,
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < rdy_pct) ? 1 : 0,
                 ($urandom_range(0, 199) != 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
